ram_arbiter: RTL and testbench

- Shares the single off-chip SRAM between the CPU's instruction-fetch port (read-only) and data-memory port (read/write).
- Arbitrates between the two ports and sequences the SRAM control strobes through a fixed multi-cycle access.
- Returns read data and a one-cycle done pulse to the requester that was served.
- Sits between the fetch/memory-stage controllers and the SRAM pins.

---
 rtl/ram_arbiter.sv | 159 +++++++++++++++
 tb/tb_ram_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one asynchronous SRAM between the instruction-fetch port (read-only)
// and the data-memory port (read/write). A single FSM grants one port, then
// walks the SRAM strobes through SETUP -> ACCESS (WAIT_CYCLES) -> DONE. The
// served port then sees a one-cycle done pulse with its read data.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   inst_req/addr       fetch request (level, held until inst_done)
//   inst_rdata/done     last fetched word, one-cycle completion pulse
//   data_req/we/addr/wdata  data request (level, held until data_done)
//   data_rdata/done     last read word, one-cycle completion pulse
//   ram_addr/dout/din   SRAM address and data buses
//   ram_dout_en         high while the SRAM data bus is driven by us
//   ram_ce_n/oe_n/we_n  SRAM strobes, active-low
//   busy                high in any state other than IDLE
//
// WAIT_CYCLES must be at least 1.

module ram_arbiter #(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 16,
    parameter int                WAIT_CYCLES = 2,
    parameter logic [DATA_W-1:0] NOP_WORD    = 16'h0800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_done,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dout,
    input  logic [DATA_W-1:0] ram_din,
    output logic              ram_dout_en,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic              busy
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             we_lat;
    // Port granted most recently; also selects which port is served now.
    logic             last_inst;
    logic             pick_data;

    // Data wins when it is the only requester, or on a tie when inst was
    // granted last time (strict alternation).
    always_comb begin
        pick_data = data_req && (!inst_req || last_inst);
    end

    // The address, write flag and write data are captured into ram_addr,
    // we_lat and ram_dout at grant, so later input changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            we_lat      <= 1'b0;
            last_inst   <= 1'b1;
            ram_addr    <= '0;
            ram_dout    <= '0;
            ram_dout_en <= 1'b0;
            ram_ce_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            inst_done   <= 1'b0;
            data_done   <= 1'b0;
            busy        <= 1'b0;
            inst_rdata  <= NOP_WORD;
            data_rdata  <= '0;
        end else begin
            inst_done <= 1'b0;
            data_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (inst_req || data_req) begin
                        state    <= SETUP;
                        busy     <= 1'b1;
                        ram_ce_n <= 1'b0;
                        if (pick_data) begin
                            last_inst   <= 1'b0;
                            ram_addr    <= data_addr;
                            we_lat      <= data_we;
                            ram_dout_en <= data_we;
                            if (data_we) begin
                                ram_dout <= data_wdata;
                            end
                        end else begin
                            last_inst   <= 1'b1;
                            ram_addr    <= inst_addr;
                            we_lat      <= 1'b0;
                            ram_dout_en <= 1'b0;
                        end
                    end
                end
                SETUP: begin
                    state    <= ACCESS;
                    wait_cnt <= CNT_INIT;
                    if (we_lat) begin
                        ram_we_n <= 1'b0;
                    end else begin
                        ram_oe_n <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == '0) begin
                        // Read data is sampled on the edge that ends the
                        // strobe, while oe_n is still low.
                        state    <= DONE;
                        ram_ce_n <= 1'b1;
                        ram_oe_n <= 1'b1;
                        ram_we_n <= 1'b1;
                        if (last_inst) begin
                            inst_rdata <= ram_din;
                            inst_done  <= 1'b1;
                        end else begin
                            data_done <= 1'b1;
                            if (!we_lat) begin
                                data_rdata <= ram_din;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    // Always via IDLE so the held req of the port just
                    // served is not granted again straight away.
                    state       <= IDLE;
                    busy        <= 1'b0;
                    ram_dout_en <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Self-checking bench for ram_arbiter with default parameters. A vector
// table walks a fetch, a data write and a data read cycle by cycle; hand
// sequences cover reset, contention, reset during a write and address latching.

module tb_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [15:0] inst_addr;
    logic [15:0] inst_rdata;
    logic        inst_done;
    logic        data_req;
    logic        data_we;
    logic [15:0] data_addr;
    logic [15:0] data_wdata;
    logic [15:0] data_rdata;
    logic        data_done;
    logic [15:0] ram_addr;
    logic [15:0] ram_dout;
    logic [15:0] ram_din;
    logic        ram_dout_en;
    logic        ram_ce_n;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic        busy;

    int tests_run;
    int tests_failed;

    // Control bundle: {ce_n, oe_n, we_n, dout_en, inst_done, data_done, busy}
    typedef struct {
        logic        inst_req;
        logic [15:0] inst_addr;
        logic        data_req;
        logic        data_we;
        logic [15:0] data_addr;
        logic [15:0] data_wdata;
        logic [15:0] ram_din;
        logic [6:0]  exp_ctl;
        logic [15:0] exp_addr;
        logic [15:0] exp_dout;
        logic [15:0] exp_irdata;
        logic [15:0] exp_drdata;
    } vec_t;

    vec_t vecs [16];

    ram_arbiter #(
        .ADDR_W     (16),
        .DATA_W     (16),
        .WAIT_CYCLES(2),
        .NOP_WORD   (16'h0800)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .inst_done  (inst_done),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_done  (data_done),
        .ram_addr   (ram_addr),
        .ram_dout   (ram_dout),
        .ram_din    (ram_din),
        .ram_dout_en(ram_dout_en),
        .ram_ce_n   (ram_ce_n),
        .ram_oe_n   (ram_oe_n),
        .ram_we_n   (ram_we_n),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        inst_req   = v.inst_req;
        inst_addr  = v.inst_addr;
        data_req   = v.data_req;
        data_we    = v.data_we;
        data_addr  = v.data_addr;
        data_wdata = v.data_wdata;
        ram_din    = v.ram_din;
    endtask

    // Ticks until a done pulse (bounded), then checks which port finished
    // and after how many cycles.
    task automatic waitDone(input string name, input logic exp_inst, input int exp_cycles);
        int  cycles;
        bit  seen;
        cycles = 0;
        seen   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cycles++;
            if (inst_done || data_done) begin
                seen = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("[TB] FAIL %s: no done pulse within 20 cycles", name);
        end else begin
            checkOutput({name, " port"}, {14'd0, inst_done, data_done}, {14'd0, exp_inst, !exp_inst});
            checkOutput({name, " latency"}, 16'(cycles), 16'(exp_cycles));
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        vecs[0]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 7'b0110001, 16'h0010, 16'h0000, 16'h0800, 16'h0000};
        vecs[1]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 7'b0010001, 16'h0010, 16'h0000, 16'h0800, 16'h0000};
        vecs[2]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 7'b0010001, 16'h0010, 16'h0000, 16'h0800, 16'h0000};
        vecs[3]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 7'b1110101, 16'h0010, 16'h0000, 16'h1234, 16'h0000};
        vecs[4]  = '{1'b0, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 7'b1110000, 16'h0010, 16'h0000, 16'h1234, 16'h0000};
        vecs[5]  = '{1'b0, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 7'b1110000, 16'h0010, 16'h0000, 16'h1234, 16'h0000};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h8000, 16'hBEEF, 16'h5555, 7'b0111001, 16'h8000, 16'hBEEF, 16'h1234, 16'h0000};
        vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h8000, 16'hBEEF, 16'h5555, 7'b0101001, 16'h8000, 16'hBEEF, 16'h1234, 16'h0000};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h8000, 16'hBEEF, 16'h5555, 7'b0101001, 16'h8000, 16'hBEEF, 16'h1234, 16'h0000};
        vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h8000, 16'hBEEF, 16'h5555, 7'b1111011, 16'h8000, 16'hBEEF, 16'h1234, 16'h0000};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h8000, 16'hBEEF, 16'h5555, 7'b1110000, 16'h8000, 16'hBEEF, 16'h1234, 16'h0000};
        vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0042, 16'h0000, 16'hA5A5, 7'b0110001, 16'h0042, 16'h0000, 16'h1234, 16'h0000};
        vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0042, 16'h0000, 16'hA5A5, 7'b0010001, 16'h0042, 16'h0000, 16'h1234, 16'h0000};
        vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0042, 16'h0000, 16'hA5A5, 7'b0010001, 16'h0042, 16'h0000, 16'h1234, 16'h0000};
        vecs[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0042, 16'h0000, 16'hA5A5, 7'b1110011, 16'h0042, 16'h0000, 16'h1234, 16'hA5A5};
        vecs[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0042, 16'h0000, 16'hA5A5, 7'b1110000, 16'h0042, 16'h0000, 16'h1234, 16'hA5A5};

        // Reset held with both requests high.
        rst        = 1'b0;
        inst_req   = 1'b1;
        data_req   = 1'b1;
        data_we    = 1'b0;
        inst_addr  = 16'h0100;
        data_addr  = 16'h0200;
        data_wdata = 16'h0000;
        ram_din    = 16'h1111;
        tick();
        tick();
        checkOutput("reset ctl", {9'd0, ram_ce_n, ram_oe_n, ram_we_n, ram_dout_en, inst_done, data_done, busy}, 16'h0070);
        checkOutput("reset inst_rdata", inst_rdata, 16'h0800);
        checkOutput("reset data_rdata", data_rdata, 16'h0000);
        checkOutput("reset ram_addr", ram_addr, 16'h0000);
        checkOutput("reset ram_dout", ram_dout, 16'h0000);

        // Contention from reset release: data first, then inst.
        rst = 1'b1;
        waitDone("tie1 data first", 1'b0, 4);
        checkOutput("tie1 ram_addr", ram_addr, 16'h0200);
        checkOutput("tie1 data_rdata", data_rdata, 16'h1111);
        ram_din = 16'h2222;
        waitDone("tie2 inst second", 1'b1, 5);
        checkOutput("tie2 inst_rdata", inst_rdata, 16'h2222);
        checkOutput("tie2 data_rdata kept", data_rdata, 16'h1111);
        inst_req = 1'b0;
        data_req = 1'b0;
        tick();
        // Serve data alone, then a fresh tie must go to inst.
        data_req = 1'b1;
        waitDone("solo data", 1'b0, 4);
        inst_req = 1'b1;
        waitDone("tie3 inst wins", 1'b1, 5);
        inst_req = 1'b0;
        data_req = 1'b0;
        tick();
        tick();

        // Clean reset, then the vector table.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d ctl", i), {9'd0, ram_ce_n, ram_oe_n, ram_we_n, ram_dout_en, inst_done, data_done, busy}, {9'd0, vecs[i].exp_ctl});
            checkOutput($sformatf("vec%0d ram_addr", i), ram_addr, vecs[i].exp_addr);
            checkOutput($sformatf("vec%0d inst_rdata", i), inst_rdata, vecs[i].exp_irdata);
            checkOutput($sformatf("vec%0d data_rdata", i), data_rdata, vecs[i].exp_drdata);
            if (vecs[i].exp_ctl[3]) begin
                checkOutput($sformatf("vec%0d ram_dout", i), ram_dout, vecs[i].exp_dout);
            end
        end

        // Reset during the second ACCESS cycle of a write.
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_addr  = 16'h0300;
        data_wdata = 16'h0BAD;
        tick();
        tick();
        tick();
        checkOutput("midwrite we_n low", {15'd0, ram_we_n}, 16'h0000);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midwrite async strobes", {13'd0, ram_ce_n, ram_we_n, ram_dout_en}, 16'h0006);
        tick();
        checkOutput("midwrite no done 1", {14'd0, data_done, busy}, 16'h0000);
        tick();
        checkOutput("midwrite no done 2", {14'd0, data_done, busy}, 16'h0000);
        rst = 1'b1;
        waitDone("midwrite restart", 1'b0, 4);
        checkOutput("midwrite restart addr", ram_addr, 16'h0300);
        data_req = 1'b0;
        data_we  = 1'b0;
        tick();

        // Fetch address is latched at grant; held req refetches after IDLE.
        inst_req  = 1'b1;
        inst_addr = 16'h0020;
        ram_din   = 16'h7777;
        tick();
        inst_addr = 16'h0030;
        checkOutput("latch setup addr", ram_addr, 16'h0020);
        tick();
        checkOutput("latch access addr", ram_addr, 16'h0020);
        waitDone("fetch1", 1'b1, 2);
        checkOutput("fetch1 rdata", inst_rdata, 16'h7777);
        ram_din = 16'h8888;
        tick();
        checkOutput("refetch idle gap", {15'd0, busy}, 16'h0000);
        tick();
        checkOutput("refetch setup addr", ram_addr, 16'h0030);
        checkOutput("refetch setup ce_n", {15'd0, ram_ce_n}, 16'h0000);
        waitDone("fetch2", 1'b1, 3);
        checkOutput("fetch2 rdata", inst_rdata, 16'h8888);
        inst_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
